i2s_mic_ulaw_packer: RTL and testbench
======================================

Name: i2s_mic_ulaw_packer

Overview:
- Captures the left-channel 16-bit sample of each I2S frame from a microphone ADC and compresses it to 8-bit μ-law.
- Packs four consecutive μ-law bytes into one 32-bit word for the monitor/keyboard link logic.
- Runs entirely in the monitor clock domain. bclk, lrck and data are oversampled through synchronizer flip-flops (FF2SyncN-style); conversion logic is LIN2MLAW-style.

Parameters:
- SYNC_STAGES, 2: synchronizer depth for bclk, lrck and audio_data_in. All three use an identical depth so they stay aligned.

Ports:
- clk  in  1  monitor clock; must be ≥4× bclk (each bclk phase ≥2 clk periods).
- rst_n  in  1  asynchronous active-low reset.
- record_start  in  1  one-clk pulse; begins recording.
- record_stop  in  1  one-clk pulse; ends recording.
- bclk  in  1  I2S bit clock (asynchronous, sampled as data).
- audio_data_in  in  1  I2S serial data; changes on bclk falling edge.
- lrck  in  1  I2S word select; 0 = left channel.
- mic_data  out  32  packed μ-law word; first byte in [31:24], fourth byte in [7:0].
- mic_data_valid  out  1  word ready.
- mic_data_retrieved  in  1  consumer acknowledge pulse.
- mic_debug  out  2  [0] = record_active, [1] = mic_data_valid.

Behaviour:
- Reset values: mic_data = 0, mic_data_valid = 0, mic_debug = 0. Also cleared: record_active, filled flag, byte counter, bit counter, shift register.
- Record control:
  - record_stop clears record_active; otherwise record_start sets it. Stop wins if both are asserted.
  - record_start also clears the byte counter and the filled flag.
- I2S receive (on synchronized bclk rising edges only):
  - A falling lrck detected at a bclk rise, relative to the lrck value at the previous bclk rise, clears the bit counter. The bit shifted on that edge is the I2S one-bit delay.
  - The next 16 bclk rises shift audio_data_in MSB-first into a 16-bit register.
  - Bit counter saturates at 16. When it reaches 16, a one-clk sample_ready strobe fires once per frame.
  - Right channel is ignored. A frame truncated by an early lrck fall restarts capture and produces no strobe.
- μ-law conversion (combinational) on x = sample[15:3], 13-bit two's complement:
  - sign = x[12]; mag = sign ? ~x[11:0] : x[11:0].
  - b = mag + 33 (13 bits).
  - seg = (index of highest set bit in b[12:5]) − 5.
  - mant = the 4 bits directly below that leading one.
  - out = ~{sign, seg[2:0], mant[3:0]}.
- Packing:
  - On sample_ready, when record_active and not filled: write the byte to lane byte_cnt (0→[31:24] … 3→[7:0]) and increment byte_cnt, wrapping 3→0.
  - Writing lane 3 sets filled.
- Handshake:
  - mic_data_valid = record_active & filled.
  - mic_data_retrieved while filled clears filled on the next clk, and mic_data holds its value.
  - Strobes arriving while filled or while inactive are dropped and byte_cnt does not advance.
  - mic_data_retrieved while not filled is ignored.
- Latency: valid rises 1 clk after the strobe that writes lane 3. The strobe itself occurs SYNC_STAGES+1 clk after the 17th post-edge bclk rise.

Optional Feature:
- Macro MIC_STOP_FLUSH_EN.
- Defined:
  - On record_stop with byte_cnt ≠ 0 and not filled: fill the remaining lanes with 0xFF (μ-law silence), set filled, and set flush_pending.
  - mic_data_valid = (record_active | flush_pending) & filled.
  - flush_pending clears on retrieve or on reset.
- Undefined: partial words are discarded at stop, and valid drops immediately with record_active.

Test Plan:
- Start recording; send left samples 5A5A, A5A5, 0001, FFFF (right channel = complements) → mic_data = 0x9919FF7F with valid high; retrieve pulse → valid low 1 clk later.
- Left samples 9696, AAAA, AAAA, AAAA → second word packed correctly per the conversion formula after the first word is retrieved; the ninth sample lands in lane 0 of the third word.
- Hold mic_data_retrieved low after a full word, then send 4 more frames → valid stays high, mic_data unchanged, and the frames are dropped.
- Send frames before record_start or after record_stop → no valid and byte_cnt unchanged. A simultaneous start+stop leaves recording inactive.
- Assert rst_n low mid-frame and mid-word → all outputs 0 immediately; after release, the next full frame writes lane 0.
- With MIC_STOP_FLUSH_EN: stop after 2 samples (5A5A, A5A5) → mic_data = 0x9919FFFF, valid high until retrieved.

Source files
------------

// File: rtl/i2s_mic_ulaw_packer.sv
// I2S microphone capture: left 16-bit sample -> 8-bit mu-law, four bytes packed per 32-bit word.
// Optional MIC_STOP_FLUSH_EN: record_stop pads a partial word with mu-law silence and presents it.
module i2s_mic_ulaw_packer #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        record_start,
  input  logic        record_stop,
  input  logic        bclk,
  input  logic        audio_data_in,
  input  logic        lrck,
  output logic [31:0] mic_data,
  output logic        mic_data_valid,
  input  logic        mic_data_retrieved,
  output logic [1:0]  mic_debug
);

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, data_sync_q;
  logic                   bclk_s, lrck_s, data_s;
  logic                   bclk_prev_q, bclk_rise;
  logic                   lrck_prev_q, lrck_prev_d, lrck_fall;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [15:0]            shift_q, shift_d;
  logic                   sample_ready_q, sample_ready_d;

  logic                   active_q, active_d;
  logic                   filled_q, filled_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [31:0]            data_q, data_d;
`ifdef MIC_STOP_FLUSH_EN
  logic                   flush_pending_q, flush_pending_d;
`endif

  logic [12:0] x, b;
  logic        sgn;
  logic [11:0] mag;
  logic [2:0]  seg;
  logic [3:0]  mant;
  logic [7:0]  ulaw;
  logic        unused_lsbs;

  // All three inputs share one depth so bclk edges line up with lrck/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      data_sync_q <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], lrck};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], audio_data_in};
      bclk_prev_q <= bclk_s;
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign data_s    = data_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_fall = lrck_prev_q & ~lrck_s;

  // The rise that sees lrck fall carries the one-bit delay; the next 16 rises are the sample.
  always_comb begin
    lrck_prev_d    = lrck_prev_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    sample_ready_d = 1'b0;
    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      if (lrck_fall) begin
        bit_cnt_d = 5'd0;
      end else if (bit_cnt_q != 5'd16) begin
        shift_d        = {shift_q[14:0], data_s};
        bit_cnt_d      = bit_cnt_q + 5'd1;
        sample_ready_d = (bit_cnt_q == 5'd15);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lrck_prev_q    <= 1'b0;
      bit_cnt_q      <= 5'd0;
      shift_q        <= 16'd0;
      sample_ready_q <= 1'b0;
    end else begin
      lrck_prev_q    <= lrck_prev_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      sample_ready_q <= sample_ready_d;
    end
  end

  assign unused_lsbs = ^shift_q[2:0];

  // Linear-to-mu-law on the top 13 bits of the sample.
  always_comb begin
    x    = shift_q[15:3];
    sgn  = x[12];
    mag  = sgn ? ~x[11:0] : x[11:0];
    b    = {1'b0, mag} + 13'd33;
    seg  = 3'd0;
    mant = b[4:1];
    if (b[12]) begin
      seg = 3'd7; mant = b[11:8];
    end else if (b[11]) begin
      seg = 3'd6; mant = b[10:7];
    end else if (b[10]) begin
      seg = 3'd5; mant = b[9:6];
    end else if (b[9]) begin
      seg = 3'd4; mant = b[8:5];
    end else if (b[8]) begin
      seg = 3'd3; mant = b[7:4];
    end else if (b[7]) begin
      seg = 3'd2; mant = b[6:3];
    end else if (b[6]) begin
      seg = 3'd1; mant = b[5:2];
    end
    ulaw = ~{sgn, seg, mant};
  end

  always_comb begin
    active_d   = active_q;
    filled_d   = filled_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
`ifdef MIC_STOP_FLUSH_EN
    flush_pending_d = flush_pending_q;
`endif
    if (record_stop) begin
      active_d = 1'b0;
    end else if (record_start) begin
      active_d = 1'b1;
    end
    if (mic_data_retrieved && filled_q) begin
      filled_d = 1'b0;
`ifdef MIC_STOP_FLUSH_EN
      flush_pending_d = 1'b0;
`endif
    end
    if (sample_ready_q && active_q && !filled_q) begin
      unique case (byte_cnt_q)
        2'd0:    data_d[31:24] = ulaw;
        2'd1:    data_d[23:16] = ulaw;
        2'd2:    data_d[15:8]  = ulaw;
        default: data_d[7:0]   = ulaw;
      endcase
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) filled_d = 1'b1;
    end
    if (record_start) begin
      byte_cnt_d = 2'd0;
      filled_d   = 1'b0;
    end
`ifdef MIC_STOP_FLUSH_EN
    // Pad the unwritten lanes with mu-law silence so the partial word is still delivered.
    if (record_stop && byte_cnt_d != 2'd0 && !filled_d) begin
      unique case (byte_cnt_d)
        2'd1:    data_d[23:0] = 24'hFF_FFFF;
        2'd2:    data_d[15:0] = 16'hFFFF;
        default: data_d[7:0]  = 8'hFF;
      endcase
      filled_d        = 1'b1;
      flush_pending_d = 1'b1;
      byte_cnt_d      = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      filled_q   <= 1'b0;
      byte_cnt_q <= 2'd0;
      data_q     <= 32'd0;
`ifdef MIC_STOP_FLUSH_EN
      flush_pending_q <= 1'b0;
`endif
    end else begin
      active_q   <= active_d;
      filled_q   <= filled_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
`ifdef MIC_STOP_FLUSH_EN
      flush_pending_q <= flush_pending_d;
`endif
    end
  end

`ifdef MIC_STOP_FLUSH_EN
  assign mic_data_valid = (active_q | flush_pending_q) & filled_q;
`else
  assign mic_data_valid = active_q & filled_q;
`endif
  assign mic_data  = data_q;
  assign mic_debug = {mic_data_valid, active_q};

endmodule

// File: tb/tb_i2s_mic_ulaw_packer.sv
// Directed bench for i2s_mic_ulaw_packer: I2S frames in, packed mu-law words checked against
// hand-computed values.
module tb_i2s_mic_ulaw_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        record_start;
  logic        record_stop;
  logic        bclk;
  logic        audio_data_in;
  logic        lrck;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic        mic_data_retrieved;
  logic [1:0]  mic_debug;

  int checks = 0;
  int errors = 0;

`ifdef MIC_STOP_FLUSH_EN
  localparam logic [31:0] StopWord  = 32'h9919_FFFF;
  localparam logic        StopValid = 1'b1;
  localparam logic [1:0]  StopDebug = 2'b10;
`else
  localparam logic [31:0] StopWord  = 32'h9919_9919;
  localparam logic        StopValid = 1'b0;
  localparam logic [1:0]  StopDebug = 2'b00;
`endif

  i2s_mic_ulaw_packer #(.SYNC_STAGES(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .record_start       (record_start),
    .record_stop        (record_stop),
    .bclk               (bclk),
    .audio_data_in      (audio_data_in),
    .lrck               (lrck),
    .mic_data           (mic_data),
    .mic_data_valid     (mic_data_valid),
    .mic_data_retrieved (mic_data_retrieved),
    .mic_debug          (mic_debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bclk period: data/lrck change with the falling edge, 4 clk per phase.
  task automatic bit_cycle(input logic lr, input logic d);
    @(negedge clk);
    bclk = 1'b0;
    lrck = lr;
    audio_data_in = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] left);
    logic [15:0] right;
    right = ~left;
    bit_cycle(1'b0, 1'b0);
    for (int i = 15; i >= 1; i--) bit_cycle(1'b0, left[i]);
    bit_cycle(1'b1, left[0]);
    for (int i = 15; i >= 1; i--) bit_cycle(1'b1, right[i]);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) record_start = 1'b1;
    if (which == 1) record_stop = 1'b1;
    if (which == 2) begin record_start = 1'b1; record_stop = 1'b1; end
    if (which == 3) mic_data_retrieved = 1'b1;
    @(negedge clk);
    record_start = 1'b0;
    record_stop = 1'b0;
    mic_data_retrieved = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    record_start = 1'b0;
    record_stop = 1'b0;
    bclk = 1'b0;
    audio_data_in = 1'b0;
    lrck = 1'b1;
    mic_data_retrieved = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", mic_data, 32'h0);
    check("reset_valid", {31'd0, mic_data_valid}, 32'd0);
    check("reset_debug", {30'd0, mic_debug}, 32'd0);
    rst_n = 1'b1;
    bit_cycle(1'b1, 1'b0);

    // Not recording: frame dropped.
    send_frame(16'h5A5A);
    check("idle_data", mic_data, 32'h0);
    check("idle_valid", {31'd0, mic_data_valid}, 32'd0);

    pulse(2);
    check("start_stop_inactive", {30'd0, mic_debug}, 32'd0);

    pulse(0);
    check("start_debug", {30'd0, mic_debug}, 32'd1);
    send_frame(16'h5A5A);
    send_frame(16'hA5A5);
    send_frame(16'h0001);
    check("partial_word1", mic_data, 32'h9919_FF00);
    check("partial_valid", {31'd0, mic_data_valid}, 32'd0);
    send_frame(16'hFFFF);
    check("word1", mic_data, 32'h9919_FF7F);
    check("word1_valid", {31'd0, mic_data_valid}, 32'd1);
    check("word1_debug", {30'd0, mic_debug}, 32'd3);

    // Unretrieved word: further frames dropped.
    send_frame(16'h1234);
    send_frame(16'h4321);
    send_frame(16'h0F0F);
    send_frame(16'h7777);
    check("hold_data", mic_data, 32'h9919_FF7F);
    check("hold_valid", {31'd0, mic_data_valid}, 32'd1);

    pulse(3);
    check("retrieve_valid", {31'd0, mic_data_valid}, 32'd0);
    check("retrieve_data_held", mic_data, 32'h9919_FF7F);

    send_frame(16'h9696);
    send_frame(16'hAAAA);
    send_frame(16'hAAAA);
    send_frame(16'hAAAA);
    check("word2", mic_data, 32'h151A_1A1A);
    check("word2_valid", {31'd0, mic_data_valid}, 32'd1);
    pulse(3);
    send_frame(16'h0001);
    check("ninth_lane0", mic_data, 32'hFF1A_1A1A);
    check("ninth_valid", {31'd0, mic_data_valid}, 32'd0);

    pulse(3);
    check("retrieve_unfilled", {31'd0, mic_data_valid}, 32'd0);
    send_frame(16'hFFFF);
    send_frame(16'h5A5A);
    send_frame(16'hA5A5);
    check("word3", mic_data, 32'hFF7F_9919);
    check("word3_valid", {31'd0, mic_data_valid}, 32'd1);
    pulse(3);

    send_frame(16'h5A5A);
    send_frame(16'hA5A5);
    check("pre_stop_data", mic_data, 32'h9919_9919);
    pulse(1);
    check("stop_data", mic_data, StopWord);
    check("stop_valid", {31'd0, mic_data_valid}, {31'd0, StopValid});
    check("stop_debug", {30'd0, mic_debug}, {30'd0, StopDebug});
    pulse(3);
    check("stop_retrieved", {31'd0, mic_data_valid}, 32'd0);
    send_frame(16'h0001);
    check("after_stop_data", mic_data, StopWord);
    check("after_stop_valid", {31'd0, mic_data_valid}, 32'd0);

    // Reset mid-word and mid-frame.
    pulse(0);
    send_frame(16'h0001);
    send_frame(16'hFFFF);
    for (int i = 0; i < 5; i++) bit_cycle(1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    bclk = 1'b0;
    #1;
    check("midreset_data", mic_data, 32'h0);
    check("midreset_valid", {31'd0, mic_data_valid}, 32'd0);
    check("midreset_debug", {30'd0, mic_debug}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bit_cycle(1'b1, 1'b0);
    pulse(0);
    send_frame(16'h0001);
    check("post_reset_lane0", mic_data, 32'hFF00_0000);
    check("post_reset_valid0", {31'd0, mic_data_valid}, 32'd0);
    send_frame(16'hFFFF);
    send_frame(16'h5A5A);
    send_frame(16'hA5A5);
    check("post_reset_word", mic_data, 32'hFF7F_9919);
    check("post_reset_valid", {31'd0, mic_data_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
